rr_decode_arbiter: RTL
======================

RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, maximum grant hold in cycles (used only with RR_TIMEOUT_EN, legal 2..256).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  8  per-requester request, level, bit i = requester i.
REQ-005 SHALL have port done  input  1  current owner releases the resource, single-cycle pulse.
REQ-006 SHALL have port gnt  output  8  registered one-hot grant, all-zero when no owner.
REQ-007 SHALL have port gnt_idx  output  3  binary index of current owner, valid while busy=1.
REQ-008 SHALL have port busy  output  1  resource owned (state BUSY).
REQ-009 SHALL have port timeout  output  1  single-cycle pulse on forced release.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, GAP; only one state active.
REQ-011 IDLE: if req != 0, SHALL select the first set bit scanning indices last+1, last+2, ... last+8 (mod 8), load gnt_idx, enter BUSY; if req == 0, stay IDLE.
REQ-012 Latency: req sampled in IDLE at edge n SHALL produce gnt/busy asserted after edge n+1 (one cycle).
REQ-013 gnt SHALL equal the full 3-to-8 one-hot decode of gnt_idx for all 8 values (including 3'b011 -> 8'b0000_1000) while BUSY, and 8'h00 otherwise; never more than one bit set.
REQ-014 BUSY: done=1 or req[gnt_idx]=0 SHALL release: last <= gnt_idx, enter GAP; gnt reads 8'h00 from the following cycle.
REQ-015 GAP: SHALL last exactly one cycle with gnt=0, busy=0, then IDLE; requests during GAP are not granted until the IDLE arbitration.
REQ-016 done SHALL be ignored in IDLE and GAP.
REQ-017 Requests from non-owners during BUSY SHALL not affect gnt or gnt_idx.
REQ-018 Round-robin: with all 8 bits held high, successive grants SHALL visit indices in strictly increasing order mod 8, each exactly once per 8 grants.
REQ-019 gnt_idx SHALL hold its last value outside BUSY.
REQ-020 Release and new-grant conditions in the same cycle SHALL resolve as release; no same-cycle regrant.

Reset
REQ-021 rst=1 SHALL immediately (asynchronously) force state IDLE, gnt=8'h00, gnt_idx=3'd0, busy=0, timeout=0, last=3'd7, hold counter=0.
REQ-022 rst asserted during BUSY SHALL drop gnt without passing through GAP; first arbitration after release of rst SHALL favour index 0.

Configuration
REQ-023 Macro RR_TIMEOUT_EN defined: SHALL count BUSY cycles from 0 at grant; on the cycle the count reaches TIMEOUT-1 without release, SHALL force release as REQ-014 and pulse timeout for one cycle.
REQ-024 Macro RR_TIMEOUT_EN undefined: no counter logic, timeout tied 0, grant held indefinitely until done or request drop.
REQ-025 If done and timeout expiry coincide, SHALL release normally with timeout=0.

Verification
REQ-026 Reset then req=8'b0000_1000 -> after one edge gnt=8'b0000_1000, gnt_idx=3, busy=1.
REQ-027 req=8'hFF held, done pulsed 2 cycles after every grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, GAP of gnt=0 between each.
REQ-028 Owner 5 granted, req[2] rises mid-grant, done pulsed -> gnt stays 8'b0010_0000 until done, then GAP, then gnt=8'b0000_0100.
REQ-029 Owner 1 drops req[1] without done -> gnt=0 next cycle, busy=0, last=1.
REQ-030 rst pulsed asynchronously (between edges) while gnt=8'b1000_0000 -> gnt=0 immediately; after release, req=8'b1000_0001 grants index 0.
REQ-031 RR_TIMEOUT_EN, TIMEOUT=16, owner 4 never releases -> forced release after 16 BUSY cycles, timeout=1 for one cycle, next grant goes to next requester after 4.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, 3-bit owner index and a one-cycle gap after each release.
// Optional forced release after TIMEOUT busy cycles when RR_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
    $error("rr_decode_arbiter: TIMEOUT must be in 2..256");
  end

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t     state, nxt_state;
  logic [2:0] last, nxt_last, nxt_idx;
  logic [2:0] sel, cand;
  logic       found, rel, expire;

  // Scan last+1 .. last+8; the wrap to last itself comes from 3'(8) == 0.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = last + 3'(i);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign rel = (state == BUSY) && (done || !req[gnt_idx] || expire);

  always_comb begin
    nxt_state = state;
    nxt_idx   = gnt_idx;
    nxt_last  = last;
    case (state)
      IDLE: if (found) begin
        nxt_state = BUSY;
        nxt_idx   = sel;
      end
      BUSY: if (rel) begin
        nxt_state = GAP;
        nxt_last  = gnt_idx;
      end
      GAP:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= 8'h00;
      gnt_idx <= 3'd0;
      busy    <= 1'b0;
      last    <= 3'd7;
    end else begin
      gnt     <= (nxt_state == BUSY) ? (8'b1 << nxt_idx) : 8'h00;
      gnt_idx <= nxt_idx;
      busy    <= (nxt_state == BUSY);
      last    <= nxt_last;
    end
  end

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;

  assign expire = (state == BUSY) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == BUSY && !rel) cnt <= cnt + 1'b1;
      else                       cnt <= '0;
      // Pulse only when expiry alone caused the release.
      timeout <= expire && !done && req[gnt_idx];
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
